// File: rtl/tinyalu_pkg.sv
// Shared types and constants for the TinyALU and its two-port front-end arbiter.
// The arbiter's optional BUSY watchdog is enabled with ALU_ARB_TIMEOUT_EN.
package tinyalu_pkg;

   // ALU operation codes
   typedef enum logic [2:0] {
      no_op  = 3'b000,
      add_op = 3'b001,
      and_op = 3'b010,
      xor_op = 3'b011,
      mul_op = 3'b100,
      rst_op = 3'b111
   } alu_opcode_t;

   // Arbiter sequencing: accept a request, run it on the ALU, answer the requester
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } arb_state_t;

   // BUSY cycles allowed before the watchdog gives up on the ALU
   localparam int          ARB_TIMEOUT_CYCLES = 255;
   // Result returned to a requester whose operation timed out
   localparam logic [15:0] ARB_TIMEOUT_RESULT = 16'hDEAD;

   // Completion pulse pattern for a requester index
   function automatic logic [1:0] grant_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_arb_rr.sv
// Two-way round-robin winner select. The pointer names the requester that
// wins a tie; it moves past the winner each time a grant is taken.
module alu_arb_rr (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       update,
   output logic       grant
);

   logic prio;

   // A lone requester always wins; on a tie the favoured one wins
   always_comb begin
      grant = prio;
      if (req == 2'b01) begin
         grant = 1'b0;
      end else if (req == 2'b10) begin
         grant = 1'b1;
      end
   end

   // After a grant the other requester becomes favoured; requester 0 starts favoured
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prio <= 1'b0;
      end else if (update) begin
         prio <= ~grant;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one TinyALU between two requesters. A request is latched in IDLE,
// driven to the ALU with start held through BUSY, and answered with a
// one-cycle gnt_done pulse in RESP. Define ALU_ARB_TIMEOUT_EN to add a BUSY
// watchdog that returns ARB_TIMEOUT_RESULT and raises a sticky err.
module alu_arbiter
   import tinyalu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          req,
   input  logic [DATA_W-1:0]   req_A0,
   input  logic [DATA_W-1:0]   req_A1,
   input  logic [DATA_W-1:0]   req_B0,
   input  logic [DATA_W-1:0]   req_B1,
   input  alu_opcode_t         req_op0,
   input  alu_opcode_t         req_op1,
   output logic [1:0]          gnt_done,
   output logic [2*DATA_W-1:0] gnt_result,
   output logic                start,
   output logic [DATA_W-1:0]   A,
   output logic [DATA_W-1:0]   B,
   output alu_opcode_t         op,
   input  logic                alu_done,
   input  logic [2*DATA_W-1:0] alu_result,
   output logic                err
);

   localparam int RES_W = 2 * DATA_W;

   arb_state_t state;
   arb_state_t state_nxt;
   logic       take_req;
   logic       win_idx;
   logic       owner;
   logic       timeout;

   // A request is only ever accepted from IDLE; drops before this are simply unseen
   assign take_req = (state == IDLE) && (|req);

   alu_arb_rr u_rr (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .update  (take_req),
      .grant   (win_idx)
   );

`ifdef ALU_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(ARB_TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] busy_cnt;
   logic            err_r;

   // Last permitted BUSY cycle: the ALU has had ARB_TIMEOUT_CYCLES cycles of start
   assign timeout = (state == BUSY) && !alu_done &&
                    (busy_cnt == TO_W'(ARB_TIMEOUT_CYCLES - 1));
   assign err     = err_r;

   // Count BUSY cycles; restarts for every new operation
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         busy_cnt <= '0;
      end else if (state != BUSY) begin
         busy_cnt <= '0;
      end else if (!alu_done) begin
         busy_cnt <= busy_cnt + TO_W'(1);
      end
   end

   // Sticky timeout flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         err_r <= 1'b0;
      end else if (timeout) begin
         err_r <= 1'b1;
      end
   end
`else
   // Without the watchdog BUSY waits for the ALU forever
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   // Sequencing: IDLE -> BUSY on any request, BUSY -> RESP on done or timeout
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|req) state_nxt = BUSY;
         BUSY:    if (alu_done || timeout) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset in BUSY drops the in-flight operation unanswered
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ALU-side drive: operands of the winner latched once and held through BUSY
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         start <= 1'b0;
         A     <= '0;
         B     <= '0;
         op    <= no_op;
         owner <= 1'b0;
      end else if (take_req) begin
         start <= 1'b1;
         owner <= win_idx;
         A     <= win_idx ? req_A1  : req_A0;
         B     <= win_idx ? req_B1  : req_B0;
         op    <= win_idx ? req_op1 : req_op0;
      end else if ((state == BUSY) && (alu_done || timeout)) begin
         start <= 1'b0;
      end
   end

   // Requester-side response: one-cycle pulse to the owner, result held afterwards
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         gnt_done   <= 2'b00;
         gnt_result <= '0;
      end else if ((state == BUSY) && alu_done) begin
         gnt_done   <= grant_onehot(owner);
         gnt_result <= alu_result;
      end else if (timeout) begin
         gnt_done   <= grant_onehot(owner);
         gnt_result <= RES_W'(ARB_TIMEOUT_RESULT);
      end else begin
         gnt_done   <= 2'b00;
      end
   end

endmodule
